isa_instr_sequencer: RTL and testbench

//  Producer side of the 20-bit ISA instruction interface: stores a short program
//  of instruction words and issues them in order to the ISA datapath over a

---
 rtl/isa_instr_sequencer.sv | 89 ++++++++
 tb/tb_isa_instr_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/isa_instr_sequencer.sv
// Program sequencer for the 20-bit ISA datapath: holds a small instruction store
// and issues a run of words in order over a valid/ready handshake.
module isa_instr_sequencer #(
    parameter int IW    = 20,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [IW-1:0] load_data,
    input  logic          start,
    input  logic [AW:0]   len,
    output logic [IW-1:0] instr,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pc
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [AW:0]   len_q;
    logic [IW-1:0] mem [DEPTH];

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // NOTE: the program store has no reset so it maps onto plain RAM; contents
    // survive rst and are only changed by load writes while idle.
    always_ff @(posedge clk) begin
        if (load_we && state == S_IDLE) begin
            mem[load_addr] <= load_data;
        end
    end

    // The FETCH-cycle read of mem[pc] is registered straight into instr, so a word
    // written on the same edge as start is already visible when fetched.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            len_q       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            pc    <= '0;
                            len_q <= len;
                            state <= S_FETCH;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_FETCH: begin
                    instr       <= mem[pc];
                    instr_valid <= 1'b1;
                    state       <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        // len_q is one bit wider than pc so len=DEPTH ends at pc=DEPTH-1
                        if ({1'b0, pc} == len_q - (AW+1)'(1)) begin
                            state <= S_DONE;
                        end else begin
                            pc    <= pc + 1'b1;
                            state <= S_FETCH;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_isa_instr_sequencer.sv
// Self-checking bench for isa_instr_sequencer: a queue of expected words checked at
// every handshake, plus directed literal checks of timing and boundary cases.
module tb_isa_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_we;
    logic [3:0]  load_addr;
    logic [19:0] load_data;
    logic        start;
    logic [4:0]  len;
    logic [19:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        busy;
    logic        done;
    logic [3:0]  pc;

    isa_instr_sequencer dut (
        .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .start(start), .len(len), .instr(instr),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .busy(busy),
        .done(done), .pc(pc)
    );

    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int done_cnt = 0;

    logic [19:0] mem_m [16];
    logic [19:0] exp_word [$];
    int          exp_pc [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake monitor: every accepted word must be the next expected one, and a
    // stalled word must stay valid and unchanged.
    logic        stall_prev = 1'b0;
    logic [19:0] held_instr = '0;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (stall_prev) begin
                check("valid_hold", 32'(instr_valid), 32'd1);
                if (instr_valid) check("instr_hold", 32'(instr), 32'(held_instr));
            end
            stall_prev = 1'b0;
            if (instr_valid && instr_ready) begin
                check("word_expected", 32'(exp_word.size() > 0), 32'd1);
                if (exp_word.size() > 0) begin
                    check("word", 32'(instr), 32'(exp_word.pop_front()));
                    check("word_pc", 32'(pc), 32'(exp_pc.pop_front()));
                end
            end else if (instr_valid) begin
                stall_prev = 1'b1;
                held_instr = instr;
            end
        end
    end

    task automatic load_word(input logic [3:0] a, input logic [19:0] d);
        tick();
        load_we = 1'b1; load_addr = a; load_data = d;
        mem_m[a] = d;
        tick();
        load_we = 1'b0;
    endtask

    task automatic push_prog(input int n);
        for (int i = 0; i < n; i++) begin
            exp_word.push_back(mem_m[i]);
            exp_pc.push_back(i);
        end
    endtask

    task automatic wait_valid(input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk); #1;
            seen = instr_valid;
        end
        check("wait_valid", 32'(seen), 32'd1);
    endtask

    // Runs until the done pulse; stray loads during the run must be dropped.
    task automatic finish_run(input int d0, input int n, input bit rnd);
        int cyc = 0;
        bit got = 1'b0;
        while (!got && cyc < 400) begin
            @(negedge clk); #1;
            if (done_cnt != d0) begin
                got = 1'b1;
            end else begin
                tick();
                instr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (rnd) begin
                    load_we   = ($urandom_range(0, 2) == 0);
                    load_addr = 4'($urandom);
                    load_data = 20'($urandom);
                end
                cyc++;
            end
        end
        load_we = 1'b0;
        check("run_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("queue_empty", 32'(exp_word.size()), 32'd0);
        if (n > 0) check("end_pc", 32'(pc), 32'(n - 1));
        tick();
        @(negedge clk); #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_valid", 32'(instr_valid), 32'd0);
    endtask

    task automatic run_prog(input int n, input bit rnd);
        int d0 = done_cnt;
        push_prog(n);
        tick();
        start = 1'b1; len = 5'(n);
        instr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        tick();
        start = 1'b0; len = 5'($urandom);
        finish_run(d0, n, rnd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic       ev [8];
        logic       ed [8];
        logic       eb [8];
        logic [19:0] ew [8];
        int d0;

        rst = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; len = '0; instr_ready = 1'b0;
        tick(); tick();
        @(negedge clk); #1;
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        tick();
        rst = 1'b0;

        load_word(4'd0, 20'h0A5C1);
        load_word(4'd1, 20'h1F2E3);
        load_word(4'd2, 20'h00401);

        // Directed run, ready held high: literal timing per cycle after start.
        ev = '{0, 1, 0, 1, 0, 1, 0, 0};
        ed = '{0, 0, 0, 0, 0, 0, 1, 0};
        eb = '{1, 1, 1, 1, 1, 1, 1, 0};
        ew = '{20'h0, 20'h0A5C1, 20'h0, 20'h1F2E3, 20'h0, 20'h00401, 20'h0, 20'h0};
        d0 = done_cnt;
        push_prog(3);
        tick();
        start = 1'b1; len = 5'd3; instr_ready = 1'b1;
        tick();
        start = 1'b0; len = 5'd9;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            check($sformatf("dir_valid_%0d", k), 32'(instr_valid), 32'(ev[k]));
            check($sformatf("dir_done_%0d", k), 32'(done), 32'(ed[k]));
            check($sformatf("dir_busy_%0d", k), 32'(busy), 32'(eb[k]));
            if (ev[k]) begin
                check($sformatf("dir_instr_%0d", k), 32'(instr), 32'(ew[k]));
                check($sformatf("dir_pc_%0d", k), 32'(pc), 32'((k - 1) / 2));
            end
        end
        check("dir_end_pc", 32'(pc), 32'd2);
        check("dir_done_once", 32'(done_cnt - d0), 32'd1);

        // Backpressure: word 1 stalled for 5 cycles.
        d0 = done_cnt;
        push_prog(3);
        tick();
        start = 1'b1; len = 5'd3; instr_ready = 1'b0;
        tick();
        start = 1'b0;
        wait_valid(10);
        check("bp_word0", 32'(instr), 32'h0A5C1);
        tick(); instr_ready = 1'b1;
        tick(); instr_ready = 1'b0;
        wait_valid(10);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_instr", 32'(instr), 32'h1F2E3);
            check("bp_hold_valid", 32'(instr_valid), 32'd1);
            @(negedge clk); #1;
        end
        tick(); instr_ready = 1'b1;
        finish_run(d0, 3, 1'b0);

        // len=0: done the cycle after start, nothing issued.
        d0 = done_cnt;
        tick();
        start = 1'b1; len = 5'd0;
        tick();
        start = 1'b0;
        @(negedge clk); #1;
        check("len0_done", 32'(done), 32'd1);
        check("len0_valid", 32'(instr_valid), 32'd0);
        check("len0_pulses", 32'(done_cnt - d0), 32'd1);
        tick();
        @(negedge clk); #1;
        check("len0_done_low", 32'(done), 32'd0);
        check("len0_busy", 32'(busy), 32'd0);

        // Mid-run reset: no done pulse, replay from mem[0].
        d0 = done_cnt;
        push_prog(3);
        tick();
        start = 1'b1; len = 5'd3; instr_ready = 1'b0;
        tick();
        start = 1'b0;
        wait_valid(10);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk); #1;
        check("mrst_valid", 32'(instr_valid), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_pc", 32'(pc), 32'd0);
        exp_word.delete();
        exp_pc.delete();
        repeat (3) begin @(negedge clk); #1; end
        check("mrst_no_done", 32'(done_cnt - d0), 32'd0);
        run_prog(3, 1'b0);

        // Full-depth run with loads attempted mid-run, then a second run to confirm.
        for (int i = 0; i < 16; i++) load_word(4'(i), 20'($urandom));
        run_prog(16, 1'b1);
        run_prog(16, 1'b0);

        // Same-edge load and start: the fetch sees the new word.
        d0 = done_cnt;
        tick();
        load_we = 1'b1; load_addr = 4'd0; load_data = 20'hBEEF5;
        mem_m[0] = 20'hBEEF5;
        start = 1'b1; len = 5'd1; instr_ready = 1'b1;
        push_prog(1);
        tick();
        load_we = 1'b0; start = 1'b0;
        finish_run(d0, 1, 1'b0);

        // Random programs, lengths and backpressure.
        for (int r = 0; r < 10; r++) begin
            repeat ($urandom_range(0, 4)) load_word(4'($urandom), 20'($urandom));
            run_prog($urandom_range(0, 16), 1'b1);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
